// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, R-type funct codes and the request kind enum.
// The single-cycle control decoders import the same constants.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        K_ADD = 3'd0,
        K_SUB = 3'd1,
        K_AND = 3'd2,
        K_OR  = 3'd3,
        K_SLT = 3'd4,
        K_LW  = 3'd5,
        K_SW  = 3'd6,
        K_BEQ = 3'd7
    } kind_e;

    // Only meaningful for the R-type kinds; I-type kinds return 0.
    function automatic logic [5:0] funct_of(kind_e k);
        case (k)
            K_ADD:   return FN_ADD;
            K_SUB:   return FN_SUB;
            K_AND:   return FN_AND;
            K_OR:    return FN_OR;
            K_SLT:   return FN_SLT;
            default: return 6'h00;
        endcase
    endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Request/response bus of the instruction encoder. Both sides use valid/ready:
// a transfer happens on a rising edge where valid and ready are both high.
interface mips_instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              full;
    logic [ADDR_W-1:0] count;
    logic [1:0]        dbg_occ;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, full, count, dbg_occ
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, full, count, dbg_occ
    );

endinterface

// File: rtl/mips_enc_fields.sv
// Combinational field encoder: kind/regs/imm/address -> 32-bit MIPS word.
// With BEQ_TARGET_EN defined, beq imm is an absolute word target turned into a PC-relative offset.
module mips_enc_fields
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [2:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       instr
);

`ifdef BEQ_TARGET_EN
    localparam bit BEQ_ABS = 1'b1;
`else
    localparam bit BEQ_ABS = 1'b0;
`endif

    logic [15:0] addr16;
    logic [15:0] beq_off;
    kind_e       k;

    always_comb begin
        k       = kind_e'(kind);
        addr16  = 16'(addr);
        // Branch offsets count from the word after the branch, wrapping mod 2**16.
        beq_off = BEQ_ABS ? (imm - (addr16 + 16'd1)) : imm;
        instr   = 32'h0;
        case (k)
            K_ADD, K_SUB, K_AND, K_OR, K_SLT:
                     instr = {OP_RTYPE, rs, rt, rd, 5'd0, funct_of(k)};
            K_LW:    instr = {OP_LW, rs, rt, imm};
            K_SW:    instr = {OP_SW, rs, rt, imm};
            K_BEQ:   instr = {OP_BEQ, rs, rt, beq_off};
            default: instr = 32'h0;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes requests into MIPS words, tags each with a sequential address
// and streams them through a 2-entry buffer. beq operand meaning set by BEQ_TARGET_EN.
module mips_instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    mips_instr_encoder_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    logic [1:0]        occ_q, occ_d;
    logic [31:0]       instr0_q, instr0_d, instr1_q, instr1_d;
    logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              full_q, full_d;

    logic [31:0]       enc_word;
    logic [ADDR_W:0]   count_inc;
    logic              in_ready_w;
    logic              push;
    logic              pop;

    mips_enc_fields #(.ADDR_W(ADDR_W)) u_fields (
        .kind  (bus.in_kind),
        .rs    (bus.in_rs),
        .rt    (bus.in_rt),
        .rd    (bus.in_rd),
        .imm   (bus.in_imm),
        .addr  (count_q),
        .instr (enc_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q    <= 2'd0;
            instr0_q <= 32'h0;
            instr1_q <= 32'h0;
            addr0_q  <= '0;
            addr1_q  <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            addr0_q  <= addr0_d;
            addr1_q  <= addr1_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Entry 0 is always the oldest word, so the output is driven straight from it.
    always_comb begin
        in_ready_w = !rst && !clear && !full_q && (occ_q != 2'd2);
        push       = bus.in_valid && in_ready_w;
        pop        = (occ_q != 2'd0) && bus.out_ready;
        count_inc  = {1'b0, count_q} + (ADDR_W+1)'(1);

        occ_d    = occ_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        addr0_d  = addr0_q;
        addr1_d  = addr1_q;
        count_d  = count_q;
        full_d   = full_q;

        // A wrap to 0 at DEPTH == 2**ADDR_W is intended; full is taken from the wide sum.
        if (push) begin
            count_d = count_inc[ADDR_W-1:0];
            if (count_inc == DEPTH_EXT) begin
                full_d = 1'b1;
            end
        end

        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    instr0_d = enc_word;
                    addr0_d  = count_q;
                end else begin
                    instr1_d = enc_word;
                    addr1_d  = count_q;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                instr0_d = instr1_q;
                addr0_d  = addr1_q;
                occ_d    = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    instr0_d = enc_word;
                    addr0_d  = count_q;
                end else begin
                    instr0_d = instr1_q;
                    addr0_d  = addr1_q;
                    instr1_d = enc_word;
                    addr1_d  = count_q;
                end
            end
            default: ;
        endcase

        // Flush wins over any push or pop in the same cycle.
        if (clear) begin
            occ_d    = 2'd0;
            instr0_d = 32'h0;
            instr1_d = 32'h0;
            addr0_d  = '0;
            addr1_d  = '0;
            count_d  = '0;
            full_d   = 1'b0;
        end
    end

    always_comb begin
        bus.in_ready  = in_ready_w;
        bus.out_valid = (occ_q != 2'd0);
        bus.out_instr = instr0_q;
        bus.out_addr  = addr0_q;
        bus.full      = full_q;
        bus.count     = count_q;
        bus.dbg_occ   = occ_q;
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed cases plus random traffic against a reference encoder.
// Honours BEQ_TARGET_EN the same way the design does.
module tb_mips_instr_encoder;
  localparam int ADDR_W = 3;
  localparam int DEPTH = 8;
  localparam int EW = 32 + ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;

  mips_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];
  int model_count = 0;
  bit model_full = 1'b0;
  int rdy_mode = 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from the instruction-format tables.
  function automatic logic [31:0] ref_encode(input int k, input int rs, input int rt,
                                             input int rd, input int imm, input int addr);
    int fn_tab[5] = '{32, 34, 36, 37, 42};
    int op_tab[8] = '{0, 0, 0, 0, 0, 35, 43, 4};
    longint w;
    int off;
    off = imm;
`ifdef BEQ_TARGET_EN
    if (k == 7) off = (imm - (addr + 1)) & 32'hFFFF;
`else
    if (k == 7) off = imm + (addr * 0);
`endif
    w = (longint'(op_tab[k]) << 26) | longint'(rs << 21) | longint'(rt << 16);
    if (k < 5) w = w | longint'(rd << 11) | longint'(fn_tab[k]);
    else w = w | longint'(off);
    return 32'(w);
  endfunction

  // Consumer ready: 0 = held low, 1 = held high, otherwise random.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: bus.out_ready = 1'b0;
        1: bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the expected queue whenever a word is taken, and checks hold under stall.
  initial begin : monitor
    logic [EW-1:0] e;
    bit stall_prev;
    logic [31:0] s_instr;
    logic [ADDR_W-1:0] s_addr;
    stall_prev = 1'b0;
    s_instr = '0;
    s_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst || clear) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_instr", bus.out_instr, s_instr);
          check("hold_addr", bus.out_addr, s_addr);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %h @%0d, expected no word", bus.out_instr, bus.out_addr);
          end else begin
            e = exp_q.pop_front();
            check("out_instr", bus.out_instr, e[31:0]);
            check("out_addr", bus.out_addr, e[EW-1:32]);
          end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        s_instr = bus.out_instr;
        s_addr = bus.out_addr;
      end
    end
  end

  // Drives one request for one cycle; called at a falling edge, returns at the next one.
  task automatic offer(input int k, input int rs, input int rt, input int rd, input int imm,
                       input bit use_want, input logic [31:0] want, output bit acc);
    logic [31:0] w;
    bus.in_valid = 1'b1;
    bus.in_kind = 3'(k);
    bus.in_rs = 5'(rs);
    bus.in_rt = 5'(rt);
    bus.in_rd = 5'(rd);
    bus.in_imm = 16'(imm);
    #1;
    check("count", bus.count, model_count % (1 << ADDR_W));
    check("full", bus.full, model_full);
    acc = bus.in_ready;
    if (model_full) check("in_ready_when_full", acc, 0);
    if (acc) begin
      w = use_want ? want : ref_encode(k, rs, rt, rd, imm, model_count);
      exp_q.push_back({ADDR_W'(model_count), w});
      model_count++;
      if (model_count == DEPTH) model_full = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input int k, input int rs, input int rt, input int rd, input int imm,
                      input bit use_want, input logic [31:0] want);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 40 && !acc; t++) offer(k, rs, rt, rd, imm, use_want, want, acc);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 40 cycles, expected accept");
    end
  endtask

  task automatic send_rand(input int kmax);
    send($urandom_range(0, kmax), $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom_range(0, 65535), 1'b0, 32'h0);
  endtask

  task automatic do_clear(input bit with_valid);
    clear = 1'b1;
    bus.in_valid = with_valid;
    #1;
    check("clear_in_ready", bus.in_ready, 0);
    @(posedge clk);
    exp_q.delete();
    model_count = 0;
    model_full = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("clear_count", bus.count, 0);
    check("clear_full", bus.full, 0);
    check("clear_out_valid", bus.out_valid, 0);
  endtask

  task automatic wait_drain(input int budget);
    rdy_mode = 1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit acc;
    bus.in_valid = 1'b0;
    bus.in_kind = '0;
    bus.in_rs = '0;
    bus.in_rt = '0;
    bus.in_rd = '0;
    bus.in_imm = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    // add r3 = r1 + r2, one-cycle latency
    send(0, 1, 2, 3, 0, 1'b1, 32'h00221820);
    #1;
    check("add_latency_valid", bus.out_valid, 1);
    check("add_latency_instr", bus.out_instr, 32'h00221820);
    check("add_latency_addr", bus.out_addr, 0);
    @(negedge clk);

    // lw then sw from a cleared address counter
    do_clear(1'b0);
    send(5, 8, 9, 0, 16'h0004, 1'b1, 32'h8D090004);
    send(6, 8, 9, 0, 16'h0004, 1'b1, 32'hAD090004);
    #1;
    check("lw_sw_count", bus.count, 2);
    wait_drain(10);

    // Back-pressure: two slots only, then in-order drain
    do_clear(1'b0);
    rdy_mode = 0;
    @(negedge clk);
    offer(1, 4, 5, 6, 0, 1'b0, 32'h0, acc);
    check("bp_accept_1", acc, 1);
    offer(2, 7, 8, 9, 0, 1'b0, 32'h0, acc);
    check("bp_accept_2", acc, 1);
    offer(3, 10, 11, 12, 0, 1'b0, 32'h0, acc);
    check("bp_reject_3", acc, 0);
    repeat (2) @(negedge clk);
    wait_drain(10);

    // beq at address 5
    do_clear(1'b0);
    repeat (5) send_rand(6);
`ifdef BEQ_TARGET_EN
    send(7, 1, 2, 0, 16'h0003, 1'b1, 32'h1022FFFD);
`else
    send(7, 1, 2, 0, 16'h0003, 1'b1, 32'h10220003);
`endif
    wait_drain(10);

    // Fill to DEPTH, counter wraps, full sticks; clear beats a pending request
    do_clear(1'b0);
    repeat (DEPTH) send_rand(7);
    #1;
    check("full_after_depth", bus.full, 1);
    check("count_wrap", bus.count, 0);
    offer(0, 1, 1, 1, 0, 1'b0, 32'h0, acc);
    check("over_depth_rejected", acc, 0);
    wait_drain(10);
    do_clear(1'b1);
    send(4, 3, 4, 5, 0, 1'b0, 32'h0);
    #1;
    check("after_clear_valid", bus.out_valid, 1);
    check("after_clear_addr", bus.out_addr, 0);
    @(negedge clk);
    do_clear(1'b1);
    wait_drain(10);

    // Reset with two words buffered
    rdy_mode = 0;
    @(negedge clk);
    send_rand(7);
    send_rand(7);
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    model_count = 0;
    model_full = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_count", bus.count, 0);
    check("midrst_full", bus.full, 0);
    check("midrst_out_instr", bus.out_instr, 0);
    check("midrst_out_addr", bus.out_addr, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    rdy_mode = 1;
    repeat (5) @(negedge clk);
    check("midrst_no_stale", bus.out_valid, 0);

    // Random traffic with random back-pressure and occasional clears
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if (model_full || $urandom_range(0, 40) == 0) begin
        do_clear(1'($urandom_range(0, 1)));
        @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        send_rand(7);
      end
    end
    wait_drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
